// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch unit.
// Issues sequential 32-bit reads into a QDEPTH-entry {pc,insn} queue ahead of decode,
// so decode stalls only stop the memory port once the queue is full. A jmp flushes the
// queue and redirects fetch; the redirected read may land in the same cycle.
module fetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rd_addr,
    output logic        rd_req,
    input  logic        rd_wait,
    input  logic [31:0] rd_data,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmppc,
    output logic        bubble,
    output logic [31:0] insn,
    output logic [31:0] pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    // Fetch/queue control state
    logic [31:0]      fpc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Entry storage: {pc, insn}; contents are don't-care until written
    logic [63:0] ram [QDEPTH];

    logic [63:0] head;
    logic        pop;
    logic        acc;

    // Head view, fetch address/request and handshake decode
    always_comb begin
        head    = ram[rd_ptr];
        bubble  = (count == '0);
        pop     = !bubble && !stall && !jmp;
        rd_addr = jmp ? jmppc : fpc;
        rd_req  = !rst && (jmp || (count < FULL) || pop);
        acc     = rd_req && !rd_wait;
        insn    = bubble ? 32'h0 : head[31:0];
        pc      = bubble ? 32'h0 : head[63:32];
    end

    // Pointer, occupancy and next-fetch-address update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // A completed read advances past the fetched word; otherwise retry the
            // same address (which is jmppc on a redirect cycle).
            if (acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                fpc    <= rd_addr + 32'd4;
            end else begin
                fpc    <= rd_addr;
            end

            if (jmp) begin
                // Flush: the head moves to the slot the redirected read (if any) fills.
                rd_ptr <= wr_ptr;
                count  <= acc ? CNT_W'(1) : '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({acc, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry write on every accepted read; storage is not reset
    always_ff @(posedge clk) begin
        if (acc) begin
            ram[wr_ptr] <= {rd_addr, rd_data};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic for fetch_queue, checked
// every cycle against a queue-based model of the fetch unit, with literal expectations
// pinning the key scenarios.
module tb_fetch_queue;

    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] rd_addr;
    logic        rd_req;
    logic        rd_wait;
    logic [31:0] rd_data;
    logic        stall;
    logic        jmp;
    logic [31:0] jmppc;
    logic        bubble;
    logic [31:0] insn;
    logic [31:0] pc;

    fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_addr(rd_addr),
        .rd_req (rd_req),
        .rd_wait(rd_wait),
        .rd_data(rd_data),
        .stall  (stall),
        .jmp    (jmp),
        .jmppc  (jmppc),
        .bubble (bubble),
        .insn   (insn),
        .pc     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: ordered list of {pc,insn} entries and the next sequential fetch address
    logic [63:0] mq[$];
    logic [31:0] mfpc;

    // Last sampled DUT values, used by the literal checks
    logic [31:0] last_addr, last_pc, last_insn;
    logic        last_bubble, last_req, last_acc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the model.
    task automatic cyc(input logic s, input logic j, input logic [31:0] jp, input logic w);
        logic [31:0] e_addr;
        logic        e_bub, e_pop, e_req, e_acc;
        stall   = s;
        jmp     = j;
        jmppc   = jp;
        rd_wait = w;
        #1;
        rd_data = mem(rd_addr);
        #1;
        e_addr = j ? jp : mfpc;
        e_bub  = (mq.size() == 0);
        e_pop  = !e_bub && !s && !j;
        e_req  = j || (mq.size() < QDEPTH) || e_pop;
        e_acc  = e_req && !w;
        chk("rd_addr", rd_addr, e_addr);
        chk("rd_req", {31'b0, rd_req}, {31'b0, e_req});
        chk("bubble", {31'b0, bubble}, {31'b0, e_bub});
        chk("pc", pc, e_bub ? 32'h0 : mq[0][63:32]);
        chk("insn", insn, e_bub ? 32'h0 : mq[0][31:0]);
        last_addr   = rd_addr;
        last_pc     = pc;
        last_insn   = insn;
        last_bubble = bubble;
        last_req    = rd_req;
        last_acc    = rd_req && !w;
        if (j) mq.delete();
        else if (e_pop) void'(mq.pop_front());
        if (e_acc) begin
            mq.push_back({e_addr, mem(e_addr)});
            mfpc = e_addr + 32'd4;
        end else begin
            mfpc = e_addr;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        jmp     = 1'b0;
        stall   = 1'b0;
        rd_wait = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_bubble", {31'b0, bubble}, 32'h1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_req", {31'b0, rd_req}, 32'h0);
        chk("rst_addr", rd_addr, 32'h0);
        mq.delete();
        mfpc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc_cnt;
        rst = 1'b1; stall = 1'b0; jmp = 1'b0; jmppc = 32'h0; rd_wait = 1'b0; rd_data = 32'h0;
        @(negedge clk);

        // 1: free-running sequential fetch
        do_reset();
        cyc(0, 0, 0, 0);
        chk("t1_addr0", last_addr, 32'h0);
        chk("t1_bub0", {31'b0, last_bubble}, 32'h1);
        cyc(0, 0, 0, 0);
        chk("t1_pc0", last_pc, 32'h0);
        chk("t1_insn0", last_insn, mem(32'h0));
        chk("t1_addr1", last_addr, 32'h4);
        cyc(0, 0, 0, 0);
        chk("t1_pc1", last_pc, 32'h4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // 2 and 5: stall fills the queue, release streams push+pop at full occupancy
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            if (last_acc) acc_cnt++;
        end
        chk("t2_accepts", acc_cnt, 32'd4);
        chk("t2_req_full", {31'b0, last_req}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_order", last_pc, 32'(i * 4));
            chk("t5_req", {31'b0, last_req}, 32'h1);
        end
        chk("t2_resume", last_addr, 32'h20);

        // 3: rd_wait holds the address while the queue drains
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        chk("t3_hold", last_addr, 32'h8);
        chk("t3_drained", {31'b0, last_bubble}, 32'h1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("t3_pc8", last_pc, 32'h8);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t3_once", {31'b0, last_bubble}, 32'h1);

        // 4: jmp with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(0, 1, 32'h100, 0);
        cyc(1, 0, 0, 0);
        chk("t4_head", last_pc, 32'h100);
        chk("t4_next", last_addr, 32'h104);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // 6: reset mid-stream, then address wrap at the top of memory
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0);
        chk("t6_restart", last_addr, 32'h0);
        cyc(1, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 0);
        chk("t6_wrap", last_addr, 32'h0);
        chk("t6_wrap_pc", last_pc, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // Randomized traffic: stalls, waits, redirects (some near the wrap point)
        for (int i = 0; i < 2500; i++) begin
            logic        s, j, w;
            logic [31:0] jp;
            s  = ($urandom_range(0, 9) < 4);
            w  = ($urandom_range(0, 9) < 3);
            j  = ($urandom_range(0, 19) == 0);
            jp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : ($urandom & 32'hFFFF_FFFC);
            cyc(s, j, jp, w);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
